imm_field_encoder: RTL and testbench

- Inverse of the immediate-extraction stage: packs rd/rs1/rs2/funct3 plus a 32-bit signed immediate into a 32-bit RV instruction word for I-type loads, S-type stores and B-type branches.
- Feeds instruction-memory preload and bench stimulus generation.
- Valid/ready input. 2-entry output FIFO with backpressure.
- Range/alignment error flag travels with each word.

---
 rtl/imm_field_encoder.sv | 153 +++++++++++++++
 tb/tb_imm_field_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_field_encoder.sv
// -----------------------------------------------------------------------------
// imm_field_encoder
//   Packs rd/rs1/rs2/funct3 and a 32-bit signed byte offset into an RV32
//   I-type load, S-type store or B-type branch word. Each encoded word, with
//   its range/alignment error flag, goes into a 2-entry output FIFO.
//
//   Optional feature macro: ENC_ERR_COUNT_EN
//     defined   : err_count is a saturating count of accepted erroneous requests
//     undefined : err_count is tied to zero and no counter is built
// -----------------------------------------------------------------------------
module imm_field_encoder #(
    parameter int DEPTH = 2,   // output FIFO entries; only 2 is supported
    parameter int CNT_W = 16   // width of the optional error counter
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        FMT_I   = 2'd0,
        FMT_S   = 2'd1,
        FMT_B   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

    // Encoder outputs
    logic [31:0] w_enc_instr;
    logic        w_enc_err;
    logic        w_fits_12;   // imm representable as 12-bit signed
    logic        w_fits_13;   // imm representable as 13-bit signed

    // FIFO state: pointers are 1 bit and simply toggle, wrapping 1 -> 0
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [31:0] r_mem_instr [2];
    logic        r_mem_err   [2];

    logic        w_push;
    logic        w_pop;

    // The upper bits must all be copies of the sign bit for the value to fit
    assign w_fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);

    // Combinational field packing and error detection for the offered request
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value held -- that is what keeps it
        // from inferring a latch.
        w_enc_instr = INSTR_NOP;
        w_enc_err   = 1'b1;
        unique case (fmt_e'(in_fmt))
            FMT_I: begin
                w_enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
                w_enc_err   = ~w_fits_12;
            end
            FMT_S: begin
                w_enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:0], OPC_STORE};
                w_enc_err   = ~w_fits_12;
            end
            FMT_B: begin
                w_enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], OPC_BRANCH};
                w_enc_err   = ~w_fits_13 | in_imm[0];
            end
            FMT_RSV: begin
                w_enc_instr = INSTR_NOP;
                w_enc_err   = 1'b1;
            end
            default: begin
                w_enc_instr = INSTR_NOP;
                w_enc_err   = 1'b1;
            end
        endcase
    end

    // Handshakes depend only on registered occupancy, never on out_ready
    assign in_ready  = (r_count < 2'(DEPTH));
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Head entry is presented only while valid, so an empty FIFO reads as zero
    assign out_instr = out_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
    assign out_err   = out_valid ? r_mem_err[r_rd_ptr]   : 1'b0;

    // Occupancy and pointer update; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, regardless of statement order.
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage written at the tail on the accepting edge
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; reset clears the
        // count, and outputs are gated by out_valid, so old contents are never seen.
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= w_enc_instr;
            r_mem_err[r_wr_ptr]   <= w_enc_err;
        end
    end

`ifdef ENC_ERR_COUNT_EN
    logic [CNT_W-1:0] r_err_count;

    // Saturating count of accepted requests that carried an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_push && w_enc_err && !(&r_err_count)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_field_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_field_encoder
//   Self-checking bench: directed cases for the documented encodings, error
//   rules, backpressure, streaming and reset, followed by randomized traffic.
//   A queue-based reference model predicts every output each cycle.
//   Define ENC_ERR_COUNT_EN here as well as in the RTL to check the counter.
// -----------------------------------------------------------------------------
module tb_imm_field_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_fmt;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] err_count;

    imm_field_encoder #(.DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } word_t;

    word_t       model_q[$];
    int unsigned model_err_cnt;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder from the field layout and numeric range rules
    function automatic word_t ref_encode(input int fmt, input int rd, input int rs1,
                                         input int rs2, input int f3, input int imm);
        word_t w;
        int    opc;
        case (fmt)
            0: begin
                opc     = 'h03;
                w.instr = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
                w.err   = (imm < -2048) || (imm > 2047);
            end
            1: begin
                opc     = 'h23;
                w.instr = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) |
                          (f3 << 12) | ((imm & 'h1F) << 7) | opc;
                w.err   = (imm < -2048) || (imm > 2047);
            end
            2: begin
                opc     = 'h63;
                w.instr = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) |
                          (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                          (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | opc;
                w.err   = (imm < -4096) || (imm > 4095) || ((imm % 2) != 0);
            end
            default: begin
                w.instr = 32'h0000_0013;
                w.err   = 1'b1;
            end
        endcase
        return w;
    endfunction

    function automatic logic [31:0] exp_err_count();
`ifdef ENC_ERR_COUNT_EN
        return model_err_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, model_q.size() != 0);
        check("in_ready", in_ready, model_q.size() < 2);
        check("out_instr", out_instr, (model_q.size() != 0) ? model_q[0].instr : 32'h0);
        check("out_err", out_err, (model_q.size() != 0) ? model_q[0].err : 1'b0);
        check("err_count", err_count, exp_err_count());
    endtask

    // One clock: drive at negedge, model the edge, check at the next negedge
    task automatic drive(input logic v, input int fmt, input int rd, input int rs1,
                         input int rs2, input int f3, input int imm, input logic ordy);
        word_t w;
        logic  acc;
        logic  pop;
        in_valid  = v;
        in_fmt    = 2'(fmt);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_imm    = imm;
        out_ready = ordy;
        @(posedge clk);
        acc = v && (model_q.size() < 2);
        pop = (model_q.size() != 0) && ordy;
        w   = ref_encode(fmt, rd, rs1, rs2, f3, imm);
        if (pop) void'(model_q.pop_front());
        if (acc) begin
            model_q.push_back(w);
            if (w.err && model_err_cnt != (1 << CNT_W) - 1) model_err_cnt++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 0, 0, 0, 0, 0, 0, ordy);
    endtask

    // Push one request into an empty FIFO, hold it one cycle, then drain it
    task automatic push_and_drain(input int fmt, input int rd, input int rs1,
                                  input int rs2, input int f3, input int imm,
                                  input string tag, input logic [31:0] exp_word,
                                  input logic exp_err);
        drive(1'b1, fmt, rd, rs1, rs2, f3, imm, 1'b0);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_word"}, out_instr, exp_word);
        check({tag, "_err"}, out_err, exp_err);
        idle(1'b0);
        check({tag, "_hold"}, out_instr, exp_word);
        idle(1'b1);
    endtask

    int boundary_imm[10] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 1};

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        model_err_cnt = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = 2'd0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct3 = 3'd0;
        in_imm    = 32'd0;
        out_ready = 1'b0;

        // Reset state
        #6;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_err_count", err_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Documented encodings
        push_and_drain(0, 5, 10, 0, 3, -8, "enc_I", 32'hFF85_3283, 1'b0);
        push_and_drain(1, 0, 2, 6, 3, 16, "enc_S", 32'h0061_3823, 1'b0);
        push_and_drain(2, 0, 1, 2, 0, -4, "enc_B", 32'hFE20_8EE3, 1'b0);

        // Error rules: misaligned branch, out-of-range load, reserved format, edge value
        drive(1'b1, 2, 0, 1, 2, 0, 3, 1'b0);
        check("err_B_misaligned", out_err, 1'b1);
        idle(1'b1);
        drive(1'b1, 0, 5, 10, 0, 3, 2048, 1'b0);
        check("err_I_range", out_err, 1'b1);
        idle(1'b1);
        drive(1'b1, 3, 5, 10, 6, 3, 100, 1'b0);
        check("err_rsv_word", out_instr, 32'h0000_0013);
        check("err_rsv_flag", out_err, 1'b1);
        idle(1'b1);
        drive(1'b1, 0, 5, 10, 0, 3, -2048, 1'b0);
        check("ok_I_min", out_err, 1'b0);
        idle(1'b1);
`ifdef ENC_ERR_COUNT_EN
        check("err_count_three", err_count, 32'd3);
`else
        check("err_count_zero", err_count, 32'd0);
`endif

        // Backpressure: three back-to-back offers with the consumer stalled
        drive(1'b1, 0, 1, 1, 0, 0, 100, 1'b0);
        drive(1'b1, 1, 0, 2, 3, 1, 200, 1'b0);
        drive(1'b1, 2, 0, 4, 5, 2, 300, 1'b0);
        check("bp_full_in_ready", in_ready, 1'b0);
        drive(1'b1, 2, 0, 4, 5, 2, 300, 1'b1);
        check("bp_reassert", in_ready, 1'b1);
        drive(1'b1, 2, 0, 4, 5, 2, 300, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("bp_drained", out_valid, 1'b0);

        // Streaming at occupancy one: push and pop on every edge
        drive(1'b1, 0, 7, 8, 0, 1, 12, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i % 3, i, i + 1, i + 2, i % 8, 4 * i - 20, 1'b1);
            check("pp_in_ready", in_ready, 1'b1);
            check("pp_out_valid", out_valid, 1'b1);
        end
        idle(1'b1);

        // Reset with the FIFO full, asserted in the middle of the low phase
        drive(1'b1, 0, 1, 2, 0, 0, 5, 1'b0);
        drive(1'b1, 1, 0, 3, 4, 2, 6, 1'b0);
        check("pre_rst_full", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_err_count", err_count, 32'd0);
        model_q.delete();
        model_err_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);
        check("post_rst_empty", out_valid, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int imm;
            case ($urandom_range(0, 3))
                0:       imm = int'($urandom_range(0, 8191)) - 4096;
                1:       imm = int'($urandom);
                2:       imm = boundary_imm[$urandom_range(0, 9)];
                default: imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
            endcase
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                  imm, $urandom_range(0, 2) != 0);
        end
        idle(1'b1);
        idle(1'b1);
        check("final_empty", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
